// File: rtl/array_op_sequencer_if.sv
// rtl/array_op_sequencer_if.sv - command, response and array-control bundle for array_op_sequencer
//
// Purpose: groups every non-clock/reset signal of the sequencer.
//   slave  modport : the sequencer side.
//   master modport : the host + array side.
// Signals (directions seen from the sequencer):
//   cmd_valid/cmd_ready/cmd_op/cmd_src_a/cmd_src_b/cmd_dst/cmd_fa/cmd_cin/cmd_data  command in
//   arr_rd_addr_up/arr_rd_addr_dn/arr_wr_addr_up/arr_wr_en (ROWS, one-hot)           array out
//   arr_data_in_up (COLS), arr_op_fa (4), arr_carry_in (1)                            array out
//   arr_rd_out_dn (COLS), arr_overflow (ROWS)                                         array in
//   rsp_valid/rsp_ready/rsp_data/rsp_ovf                                              response out
//   illegal_cnt (8)                                                                   status out
interface array_op_sequencer_if #(
    parameter int COLS = 32,
    parameter int ROWS = 32
);
    localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [AW-1:0]   cmd_src_a;
    logic [AW-1:0]   cmd_src_b;
    logic [AW-1:0]   cmd_dst;
    logic [3:0]      cmd_fa;
    logic            cmd_cin;
    logic [COLS-1:0] cmd_data;

    logic [ROWS-1:0] arr_rd_addr_up;
    logic [ROWS-1:0] arr_rd_addr_dn;
    logic [ROWS-1:0] arr_wr_addr_up;
    logic [ROWS-1:0] arr_wr_en;
    logic [COLS-1:0] arr_data_in_up;
    logic [3:0]      arr_op_fa;
    logic            arr_carry_in;
    logic [COLS-1:0] arr_rd_out_dn;
    logic [ROWS-1:0] arr_overflow;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [COLS-1:0] rsp_data;
    logic            rsp_ovf;

    logic [7:0]      illegal_cnt;

    modport slave (
        input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_fa, cmd_cin, cmd_data,
        output cmd_ready,
        output arr_rd_addr_up, arr_rd_addr_dn, arr_wr_addr_up, arr_wr_en,
        output arr_data_in_up, arr_op_fa, arr_carry_in,
        input  arr_rd_out_dn, arr_overflow,
        output rsp_valid, rsp_data, rsp_ovf,
        input  rsp_ready,
        output illegal_cnt
    );

    modport master (
        output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_fa, cmd_cin, cmd_data,
        input  cmd_ready,
        input  arr_rd_addr_up, arr_rd_addr_dn, arr_wr_addr_up, arr_wr_en,
        input  arr_data_in_up, arr_op_fa, arr_carry_in,
        output arr_rd_out_dn, arr_overflow,
        input  rsp_valid, rsp_data, rsp_ovf,
        output rsp_ready,
        input  illegal_cnt
    );
endinterface

// File: rtl/array_op_sequencer.sv
// rtl/array_op_sequencer.sv - queued WRITE/READ/COMPUTE command sequencer for a row array
//
// Purpose: accepts commands into a DEPTH-entry FIFO and runs them one at a time against
// an external row array, returning READ/COMPUTE results on a valid/ready response port.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - array_op_sequencer_if.slave (command, array control, response, illegal_cnt)
module array_op_sequencer #(
    parameter int COLS  = 32,
    parameter int ROWS  = 32,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    array_op_sequencer_if.slave  bus
);
    localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] OP_WRITE   = 2'd0;
    localparam logic [1:0] OP_READ    = 2'd1;
    localparam logic [1:0] OP_COMPUTE = 2'd2;
    localparam logic [1:0] OP_BAD     = 2'd3;

    typedef struct packed {
        logic [1:0]      op;
        logic [AW-1:0]   src_a;
        logic [AW-1:0]   src_b;
        logic [AW-1:0]   dst;
        logic [3:0]      fa;
        logic            cin;
        logic [COLS-1:0] data;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_EXEC,
        S_CAPTURE,
        S_RESP
    } state_t;

    function automatic logic [ROWS-1:0] onehot(input logic [AW-1:0] idx);
        return ROWS'(1) << idx;
    endfunction

    // ---------------------------------------------------------------- command FIFO
    cmd_t          fifo_mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    cmd_t          head;
    cmd_t          cmd_in;

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    // A pop in a full cycle frees the slot only from the next cycle on.
    assign bus.cmd_ready = !full && !rst;
    assign push  = bus.cmd_valid && bus.cmd_ready;
    assign head  = fifo_mem_q[rd_ptr_q];

    assign cmd_in = '{op:    bus.cmd_op,
                      src_a: bus.cmd_src_a,
                      src_b: bus.cmd_src_b,
                      dst:   bus.cmd_dst,
                      fa:    bus.cmd_fa,
                      cin:   bus.cmd_cin,
                      data:  bus.cmd_data};

    always_comb begin
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // ---------------------------------------------------------------- sequencer FSM
    state_t          state_q;
    logic [1:0]      op_q;
    logic [AW-1:0]   dst_q;
    logic [3:0]      fa_q;
    logic            cin_q;

    logic [ROWS-1:0] rd_up_q;
    logic [ROWS-1:0] rd_dn_q;
    logic [ROWS-1:0] wr_addr_q;
    logic [ROWS-1:0] wr_en_q;
    logic [COLS-1:0] data_in_q;
    logic [3:0]      op_fa_q;
    logic            carry_q;

    logic            rsp_valid_q;
    logic [COLS-1:0] rsp_data_q;
    logic            rsp_ovf_q;
    logic [7:0]      illegal_q;

    logic            head_bad;

    // Any out-of-range index makes the whole command illegal, whether or not the op uses it.
    assign head_bad = (head.op == OP_BAD)
                   || (32'(head.src_a) >= ROWS)
                   || (32'(head.src_b) >= ROWS)
                   || (32'(head.dst)   >= ROWS);

    // The head is consumed in IDLE, both for legal commands and for discards.
    assign pop = (state_q == S_IDLE) && !empty;

    // Array outputs are registered on entry to the state they belong to, so each
    // branch below loads the values for the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_WRITE;
            dst_q       <= '0;
            fa_q        <= '0;
            cin_q       <= 1'b0;
            rd_up_q     <= '0;
            rd_dn_q     <= '0;
            wr_addr_q   <= '0;
            wr_en_q     <= '0;
            data_in_q   <= '0;
            op_fa_q     <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            illegal_q   <= '0;
        end else begin
            rd_up_q   <= '0;
            rd_dn_q   <= '0;
            wr_addr_q <= '0;
            wr_en_q   <= '0;
            data_in_q <= '0;
            op_fa_q   <= '0;
            carry_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        if (head_bad) begin
                            if (illegal_q != 8'hFF) illegal_q <= illegal_q + 8'd1;
                        end else begin
                            op_q    <= head.op;
                            dst_q   <= head.dst;
                            fa_q    <= head.fa;
                            cin_q   <= head.cin;
                            state_q <= S_ISSUE;
                            case (head.op)
                                OP_WRITE: begin
                                    wr_addr_q <= onehot(head.dst);
                                    wr_en_q   <= onehot(head.dst);
                                    data_in_q <= head.data;
                                end
                                OP_READ: begin
                                    rd_dn_q <= onehot(head.src_a);
                                end
                                default: begin
                                    rd_up_q <= onehot(head.src_a);
                                    rd_dn_q <= onehot(head.src_b);
                                    op_fa_q <= head.fa;
                                    carry_q <= head.cin;
                                end
                            endcase
                        end
                    end
                end

                S_ISSUE: begin
                    case (op_q)
                        OP_WRITE: state_q <= S_IDLE;
                        OP_READ:  state_q <= S_CAPTURE;
                        default: begin
                            // op select and carry stay on the array while the result is written
                            state_q   <= S_EXEC;
                            op_fa_q   <= fa_q;
                            carry_q   <= cin_q;
                            wr_addr_q <= onehot(dst_q);
                            wr_en_q   <= onehot(dst_q);
                        end
                    endcase
                end

                S_EXEC: begin
                    state_q <= S_CAPTURE;
                end

                S_CAPTURE: begin
                    rsp_data_q  <= bus.arr_rd_out_dn;
                    rsp_ovf_q   <= (op_q == OP_COMPUTE) ? bus.arr_overflow[dst_q] : 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.arr_rd_addr_up = rd_up_q;
    assign bus.arr_rd_addr_dn = rd_dn_q;
    assign bus.arr_wr_addr_up = wr_addr_q;
    assign bus.arr_wr_en      = wr_en_q;
    assign bus.arr_data_in_up = data_in_q;
    assign bus.arr_op_fa      = op_fa_q;
    assign bus.arr_carry_in   = carry_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_ovf        = rsp_ovf_q;
    assign bus.illegal_cnt    = illegal_q;
endmodule

// File: tb/tb_array_op_sequencer.sv
// tb/tb_array_op_sequencer.sv - directed self-checking bench for array_op_sequencer
module tb_array_op_sequencer;
    localparam int COLS = 32;
    localparam int ROWS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   act_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    array_op_sequencer_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    array_op_sequencer #(.COLS(COLS), .ROWS(ROWS), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Toy array: each row holds a fixed word; the down port reads with one cycle latency.
    function automatic logic [31:0] mem_word(input int i);
        return (i == 3) ? 32'h1234 : 32'h1000 + 32'(i);
    endfunction

    assign bus.arr_overflow = 32'h0000_0080;

    always @(posedge clk or posedge rst) begin
        if (rst) bus.arr_rd_out_dn <= '0;
        else begin
            for (int i = 0; i < ROWS; i++)
                if (bus.arr_rd_addr_dn[i]) bus.arr_rd_out_dn <= mem_word(i);
        end
    end

    always @(negedge clk) begin
        if ((|bus.arr_rd_addr_up) || (|bus.arr_rd_addr_dn) || (|bus.arr_wr_addr_up) ||
            (|bus.arr_wr_en) || (|bus.arr_data_in_up) || (|bus.arr_op_fa) ||
            bus.arr_carry_in || bus.rsp_valid)
            act_cnt <= act_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns acc = cycle count just after the acceptance edge N.
    task automatic send(input logic [1:0] op, input int a, input int b, input int d,
                        input logic [3:0] fa, input logic cin, input logic [31:0] data,
                        output int acc);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.cmd_op    = op;
        bus.cmd_src_a = 5'(a);
        bus.cmd_src_b = 5'(b);
        bus.cmd_dst   = 5'(d);
        bus.cmd_fa    = fa;
        bus.cmd_cin   = cin;
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.cmd_ready) begin
            check_val("send_timeout", 64'(bus.cmd_ready), 64'd1);
            bus.cmd_valid = 1'b0;
            acc = cyc;
        end else begin
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b0;
            acc = cyc;
        end
    endtask

    // Lands on the negedge inside cycle N+k.
    task automatic wait_k(input int base, input int k);
        do @(negedge clk); while (cyc < base + k - 1);
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check_val("rsp_drop", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int a0;
        int sent;
        int got;
        logic go;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_src_a = '0;
        bus.cmd_src_b = '0;
        bus.cmd_dst   = '0;
        bus.cmd_fa    = '0;
        bus.cmd_cin   = 1'b0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check_val("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_val("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check_val("rst_illegal", 64'(bus.illegal_cnt), 64'd0);
        check_val("rst_wr_en", 64'(bus.arr_wr_en), 64'd0);
        rst = 1'b0;
        #1;
        check_val("post_rst_ready", 64'(bus.cmd_ready), 64'd1);

        // WRITE dst=5
        send(2'd0, 0, 0, 5, 4'd0, 1'b0, 32'hA5A5_A5A5, acc);
        for (int k = 1; k <= 4; k++) begin
            wait_k(acc, k);
            check_val($sformatf("wr_en@N+%0d", k), 64'(bus.arr_wr_en), (k == 2) ? 64'h20 : 64'h0);
            check_val($sformatf("wr_addr@N+%0d", k), 64'(bus.arr_wr_addr_up), (k == 2) ? 64'h20 : 64'h0);
            check_val($sformatf("wr_data@N+%0d", k), 64'(bus.arr_data_in_up), (k == 2) ? 64'hA5A5_A5A5 : 64'h0);
            check_val($sformatf("wr_rsp@N+%0d", k), 64'(bus.rsp_valid), 64'd0);
        end

        // READ src_a=3
        send(2'd1, 3, 0, 0, 4'd0, 1'b0, 32'h0, acc);
        for (int k = 1; k <= 4; k++) begin
            wait_k(acc, k);
            check_val($sformatf("rd_addr_dn@N+%0d", k), 64'(bus.arr_rd_addr_dn), (k == 2) ? 64'h8 : 64'h0);
            check_val($sformatf("rd_rsp_valid@N+%0d", k), 64'(bus.rsp_valid), (k == 4) ? 64'd1 : 64'd0);
        end
        check_val("rd_rsp_data", 64'(bus.rsp_data), 64'h1234);
        check_val("rd_rsp_ovf", 64'(bus.rsp_ovf), 64'd0);
        release_rsp();

        // COMPUTE src_a=1 src_b=2 dst=7 fa=1 cin=1
        send(2'd2, 1, 2, 7, 4'd1, 1'b1, 32'h0, acc);
        wait_k(acc, 2);
        check_val("cp_rd_up@N+2", 64'(bus.arr_rd_addr_up), 64'h2);
        check_val("cp_rd_dn@N+2", 64'(bus.arr_rd_addr_dn), 64'h4);
        check_val("cp_fa@N+2", 64'(bus.arr_op_fa), 64'h1);
        check_val("cp_cin@N+2", 64'(bus.arr_carry_in), 64'd1);
        check_val("cp_wr_en@N+2", 64'(bus.arr_wr_en), 64'h0);
        wait_k(acc, 3);
        check_val("cp_wr_en@N+3", 64'(bus.arr_wr_en), 64'h80);
        check_val("cp_wr_addr@N+3", 64'(bus.arr_wr_addr_up), 64'h80);
        check_val("cp_fa@N+3", 64'(bus.arr_op_fa), 64'h1);
        check_val("cp_cin@N+3", 64'(bus.arr_carry_in), 64'd1);
        check_val("cp_rd_up@N+3", 64'(bus.arr_rd_addr_up), 64'h0);
        wait_k(acc, 4);
        check_val("cp_wr_en@N+4", 64'(bus.arr_wr_en), 64'h0);
        check_val("cp_fa@N+4", 64'(bus.arr_op_fa), 64'h0);
        check_val("cp_rsp@N+4", 64'(bus.rsp_valid), 64'd0);
        wait_k(acc, 5);
        check_val("cp_rsp@N+5", 64'(bus.rsp_valid), 64'd1);
        check_val("cp_ovf", 64'(bus.rsp_ovf), 64'd1);
        check_val("cp_data", 64'(bus.rsp_data), 64'(mem_word(2)));
        release_rsp();

        // six back-to-back READs with the response held off
        sent = 0;
        got  = 0;
        @(negedge clk);
        for (int c = 0; c < 150 && got < 6; c++) begin
            if (c == 30) bus.rsp_ready = 1'b1;
            if (bus.rsp_valid && bus.rsp_ready) begin
                check_val($sformatf("b2b_rsp%0d", got), 64'(bus.rsp_data), 64'(mem_word(10 + got)));
                got++;
            end
            if (c == 12 || c == 29) begin
                check_val($sformatf("b2b_hold_data@%0d", c), 64'(bus.rsp_data), 64'(mem_word(10)));
                check_val($sformatf("b2b_hold_valid@%0d", c), 64'(bus.rsp_valid), 64'd1);
            end
            if (c == 29) begin
                check_val("b2b_accepted", 64'(sent), 64'd5);
                check_val("b2b_ready_low", 64'(bus.cmd_ready), 64'd0);
            end
            bus.cmd_valid = (sent < 6);
            bus.cmd_op    = 2'd1;
            bus.cmd_src_a = 5'(10 + sent);
            bus.cmd_src_b = '0;
            bus.cmd_dst   = '0;
            go = bus.cmd_valid && bus.cmd_ready;
            @(posedge clk);
            if (go) sent++;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check_val("b2b_sent", 64'(sent), 64'd6);
        check_val("b2b_got", 64'(got), 64'd6);

        // two illegal commands
        repeat (3) @(negedge clk);
        a0 = act_cnt;
        send(2'd3, 1, 2, 3, 4'd0, 1'b0, 32'hFFFF_FFFF, acc);
        send(2'd3, 4, 5, 6, 4'd2, 1'b1, 32'h0, acc);
        repeat (6) @(negedge clk);
        check_val("ill_cnt2", 64'(bus.illegal_cnt), 64'd2);
        check_val("ill_activity", 64'(act_cnt - a0), 64'd0);

        // saturation
        for (int i = 0; i < 260; i++) send(2'd3, 0, 0, 0, 4'd0, 1'b0, 32'h0, acc);
        repeat (4) @(negedge clk);
        check_val("ill_sat", 64'(bus.illegal_cnt), 64'd255);

        // reset during COMPUTE EXEC with two writes queued behind it
        send(2'd2, 1, 2, 7, 4'd1, 1'b1, 32'h0, acc);
        send(2'd0, 0, 0, 9, 4'd0, 1'b0, 32'h1111_1111, a0);
        send(2'd0, 0, 0, 10, 4'd0, 1'b0, 32'h2222_2222, a0);
        wait_k(acc, 3);
        check_val("rx_wr_en_pre", 64'(bus.arr_wr_en), 64'h80);
        #2 rst = 1'b1;
        #1;
        check_val("rx_wr_en", 64'(bus.arr_wr_en), 64'h0);
        check_val("rx_fa", 64'(bus.arr_op_fa), 64'h0);
        check_val("rx_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check_val("rx_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_val("rx_illegal", 64'(bus.illegal_cnt), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rx_ready_after", 64'(bus.cmd_ready), 64'd1);
        a0 = act_cnt;
        repeat (12) @(negedge clk);
        check_val("rx_no_activity", 64'(act_cnt - a0), 64'd0);

        // normal operation after reset
        send(2'd1, 4, 0, 0, 4'd0, 1'b0, 32'h0, acc);
        wait_k(acc, 4);
        check_val("post_rd_valid", 64'(bus.rsp_valid), 64'd1);
        check_val("post_rd_data", 64'(bus.rsp_data), 64'(mem_word(4)));
        release_rsp();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/array_op_sequencer.md
ARRAY_OP_SEQUENCER -- requirements
Module: array_op_sequencer

Interface
REQ-001 SHALL have parameter COLS, default 32, giving the array row width in bits.
REQ-002 SHALL have parameter ROWS, default 32, giving the array row count; AW = $clog2(ROWS).
REQ-003 SHALL have parameter DEPTH, default 4, giving command FIFO entries (power of 2).
REQ-004 SHALL have port clk  input  1  the single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  command FIFO can accept.
REQ-008 SHALL have port cmd_op  input  2  0 WRITE, 1 READ, 2 COMPUTE, 3 illegal.
REQ-009 SHALL have ports cmd_src_a, cmd_src_b, cmd_dst  input  AW each  row indices.
REQ-010 SHALL have ports cmd_fa  input  4  and cmd_cin  input  1  full-adder op select and carry.
REQ-011 SHALL have port cmd_data  input  COLS  WRITE payload.
REQ-012 SHALL have ports arr_rd_addr_up, arr_rd_addr_dn, arr_wr_addr_up, arr_wr_en  output  ROWS each  one-hot array controls.
REQ-013 SHALL have ports arr_data_in_up  output  COLS, arr_op_fa  output  4, arr_carry_in  output  1.
REQ-014 SHALL have ports arr_rd_out_dn  input  COLS and arr_overflow  input  ROWS  array results.
REQ-015 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_data  output  COLS, rsp_ovf  output  1.
REQ-016 SHALL have port illegal_cnt  output  8  count of discarded commands.

Function
REQ-017 SHALL push a command into the FIFO on a cycle with cmd_valid and cmd_ready both high; cmd_ready = FIFO not full and rst low.
REQ-018 SHALL allow push and pop in the same cycle, including the full case where a pop frees an entry only for the next cycle (cmd_ready stays low that cycle).
REQ-019 SHALL run FSM states IDLE, ISSUE, EXEC, CAPTURE, RESP; IDLE pops the FIFO head when non-empty and enters ISSUE the next cycle.
REQ-020 SHALL, for WRITE in ISSUE, drive arr_wr_addr_up and arr_wr_en one-hot at cmd_dst and arr_data_in_up = cmd_data for exactly one cycle, then return to IDLE without a response.
REQ-021 SHALL, for READ in ISSUE, drive arr_rd_addr_dn one-hot at cmd_src_a for one cycle, then in CAPTURE register arr_rd_out_dn into rsp_data with rsp_ovf = 0, then enter RESP.
REQ-022 SHALL, for COMPUTE, in ISSUE drive arr_rd_addr_up one-hot src_a, arr_rd_addr_dn one-hot src_b, arr_op_fa = cmd_fa, arr_carry_in = cmd_cin; in EXEC hold op_fa/carry_in and drive arr_wr_addr_up and arr_wr_en one-hot at dst; in CAPTURE register arr_rd_out_dn into rsp_data and arr_overflow[dst] into rsp_ovf.
REQ-023 SHALL hold rsp_valid high in RESP with rsp_data and rsp_ovf stable until rsp_ready is high, then return to IDLE the next cycle.
REQ-024 SHALL register all arr_* outputs and drive them to zero in every state and cycle other than those named above.
REQ-025 SHALL discard op 3 or any index >= ROWS in IDLE (no array activity, no response) and increment illegal_cnt, saturating at 255.
REQ-026 SHALL give latency from acceptance edge N: WRITE arr_wr_en high in cycle N+2; READ rsp_valid from N+4; COMPUTE rsp_valid from N+5, with FIFO initially empty and FSM in IDLE.
REQ-027 SHALL process commands strictly in acceptance order, one at a time.

Reset
REQ-028 SHALL, while rst is high, immediately clear the FIFO, force IDLE, and drive cmd_ready, rsp_valid, rsp_data, rsp_ovf, illegal_cnt and all arr_* outputs to 0, aborting any in-flight command with no response.
REQ-029 SHALL resume accepting commands in the first cycle after rst deasserts.

Verification
REQ-030 SHALL pass: WRITE dst=5 data=0xA5A5A5A5 -> arr_wr_en = 0x20 and arr_data_in_up = 0xA5A5A5A5 for exactly one cycle at N+2, no rsp_valid.
REQ-031 SHALL pass: READ src_a=3 with arr_rd_out_dn = 0x1234 -> arr_rd_addr_dn = 0x8 at N+2, rsp_valid at N+4 with rsp_data = 0x1234, rsp_ovf = 0.
REQ-032 SHALL pass: COMPUTE src_a=1 src_b=2 dst=7 fa=0x1 cin=1, arr_overflow[7]=1 -> rd_addr_up 0x2 / rd_addr_dn 0x4 at N+2, wr_en 0x80 at N+3, rsp_ovf = 1 at N+5.
REQ-033 SHALL pass: 6 back-to-back commands with rsp_ready low -> cmd_ready low after 4 stored plus 1 in flight, rsp_valid and rsp_data held stable, order preserved when released.
REQ-034 SHALL pass: two op=3 commands -> illegal_cnt = 2, no arr_* activity, no response.
REQ-035 SHALL pass: rst asserted during COMPUTE EXEC -> arr_wr_en = 0 immediately, FIFO empty, no response after release.
